// File: rtl/axi_wr_burst_sink.sv
// AXI4 write-channel slave that terminates write bursts.
// One AW request is accepted at a time. Each W beat is forwarded to a simple
// registered memory write port with an incrementing address. The number of
// beats actually received is checked against AWLEN. A matching burst gets an
// OKAY response, and a short or long burst gets SLVERR.
module axi_wr_burst_sink #(
  parameter int    ASIZE     = 32,
  parameter int    DSIZE     = 64,
  parameter int    IDSIZE    = 4,
  parameter int    LSIZE     = 8,
  parameter int    ADDR_STEP = 1,
  parameter int    ID        = 0,
  parameter string LOCK_ID   = "OFF"
) (
  input  logic                 axi_aclk,
  input  logic                 axi_aresetn,
  input  logic [IDSIZE-1:0]    axi_awid,
  input  logic [ASIZE-1:0]     axi_awaddr,
  input  logic [LSIZE-1:0]     axi_awlen,
  input  logic                 axi_awvalid,
  output logic                 axi_awready,
  input  logic [DSIZE-1:0]     axi_wdata,
  input  logic [DSIZE/8-1:0]   axi_wstrb,
  input  logic                 axi_wlast,
  input  logic                 axi_wvalid,
  output logic                 axi_wready,
  output logic [IDSIZE-1:0]    axi_bid,
  output logic [1:0]           axi_bresp,
  output logic                 axi_bvalid,
  input  logic                 axi_bready,
  output logic                 mem_we,
  output logic [ASIZE-1:0]     mem_addr,
  output logic [DSIZE-1:0]     mem_wdata,
  output logic [DSIZE/8-1:0]   mem_wstrb,
  output logic                 burst_done,
  output logic [15:0]          len_err_cnt
);

  localparam int SSIZE = DSIZE / 8;

  // When LOCK_ON is set, only requests that carry the configured ID are accepted.
  localparam bit                LOCK_ON  = (LOCK_ID == "ON");
  localparam logic [IDSIZE-1:0] ID_MATCH = IDSIZE'(ID);
  localparam logic [ASIZE-1:0]  STEP     = ASIZE'(ADDR_STEP);
  localparam logic [LSIZE:0]    CNT_ONE  = (LSIZE+1)'(1);
  localparam logic [1:0]        RESP_OK  = 2'b00;
  localparam logic [1:0]        RESP_ERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_q,       state_d;
  logic [ASIZE-1:0]    cur_addr_q,    cur_addr_d;
  // exp_len has one extra bit so that awlen = all-ones (2^LSIZE beats) can be represented.
  logic [LSIZE:0]      exp_len_q,     exp_len_d;
  logic [LSIZE:0]      beat_cnt_q,    beat_cnt_d;
  logic                err_q,         err_d;
  logic [IDSIZE-1:0]   bid_q,         bid_d;
  logic [1:0]          bresp_q,       bresp_d;
  logic                mem_we_q,      mem_we_d;
  logic [ASIZE-1:0]    mem_addr_q,    mem_addr_d;
  logic [DSIZE-1:0]    mem_wdata_q,   mem_wdata_d;
  logic [SSIZE-1:0]    mem_wstrb_q,   mem_wstrb_d;
  logic                burst_done_q,  burst_done_d;
  logic [15:0]         len_err_cnt_q, len_err_cnt_d;

  logic                id_ok;
  logic                aw_hs;
  logic                w_hs;
  logic                b_hs;
  logic                beat_in_range;
  logic [LSIZE:0]      beat_cnt_inc;

  // awready depends on awid combinationally, not on awvalid.
  // It is also held low while reset is asserted.
  assign id_ok       = !LOCK_ON || (axi_awid == ID_MATCH);
  assign axi_awready = axi_aresetn && (state_q == ST_IDLE) && id_ok;
  assign axi_wready  = (state_q == ST_DATA);
  assign axi_bvalid  = (state_q == ST_RESP);

  assign aw_hs = axi_awvalid && axi_awready;
  assign w_hs  = axi_wvalid  && axi_wready;
  assign b_hs  = axi_bvalid  && axi_bready;

  // The beat counter saturates so that a runaway overrun cannot wrap it back
  // into the in-range window. Once it is at all-ones it is already beyond any
  // possible exp_len.
  assign beat_cnt_inc  = (beat_cnt_q == '1) ? beat_cnt_q : (beat_cnt_q + CNT_ONE);
  assign beat_in_range = (beat_cnt_q < exp_len_q);

  assign axi_bid     = bid_q;
  assign axi_bresp   = bresp_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wstrb   = mem_wstrb_q;
  assign burst_done  = burst_done_q;
  assign len_err_cnt = len_err_cnt_q;

  // Next-state logic, memory write staging and response bookkeeping.
  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    exp_len_d     = exp_len_q;
    beat_cnt_d    = beat_cnt_q;
    err_d         = err_q;
    bid_d         = bid_q;
    bresp_d       = bresp_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wstrb_d   = mem_wstrb_q;
    burst_done_d  = 1'b0;
    len_err_cnt_d = len_err_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (aw_hs) begin
          cur_addr_d = axi_awaddr;
          exp_len_d  = {1'b0, axi_awlen} + CNT_ONE;
          bid_d      = axi_awid;
          beat_cnt_d = '0;
          err_d      = 1'b0;
          state_d    = ST_DATA;
        end
      end

      ST_DATA: begin
        if (w_hs) begin
          beat_cnt_d = beat_cnt_inc;
          if (beat_in_range) begin
            // The write is registered, so it reaches the memory port one cycle after the beat.
            mem_we_d    = 1'b1;
            mem_addr_d  = cur_addr_q;
            mem_wdata_d = axi_wdata;
            mem_wstrb_d = axi_wstrb;
            cur_addr_d  = cur_addr_q + STEP;
          end else begin
            // Overrun beat: it is accepted on the bus but dropped.
            err_d = 1'b0 | 1'b1;
          end
          if (axi_wlast) begin
            // wlast arrived before the announced number of beats.
            if (beat_cnt_inc < exp_len_q) begin
              err_d = 1'b1;
            end
            bresp_d = err_d ? RESP_ERR : RESP_OK;
            state_d = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        if (b_hs) begin
          burst_done_d = 1'b1;
          if (err_q && (len_err_cnt_q != 16'hFFFF)) begin
            len_err_cnt_d = len_err_cnt_q + 16'd1;
          end
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  // Asserting reset mid-burst simply abandons the burst.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q       <= ST_IDLE;
      cur_addr_q    <= '0;
      exp_len_q     <= '0;
      beat_cnt_q    <= '0;
      err_q         <= 1'b0;
      bid_q         <= '0;
      bresp_q       <= 2'b00;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_wstrb_q   <= '0;
      burst_done_q  <= 1'b0;
      len_err_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      exp_len_q     <= exp_len_d;
      beat_cnt_q    <= beat_cnt_d;
      err_q         <= err_d;
      bid_q         <= bid_d;
      bresp_q       <= bresp_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_wstrb_q   <= mem_wstrb_d;
      burst_done_q  <= burst_done_d;
      len_err_cnt_q <= len_err_cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_wr_burst_sink.sv
// Scoreboard bench for axi_wr_burst_sink.
// The driver computes the expected memory writes and B responses from the
// burst parameters. A negedge monitor pops and compares those expectations
// whenever the DUT writes memory or completes a B handshake.
// A second instance, with the ID lock enabled, exercises AW filtering.
module tb_axi_wr_burst_sink;

  localparam int STEP = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // main instance (LOCK_ID = "OFF")
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid, awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        burst_done;
  logic [15:0] len_err_cnt;

  // locked instance (LOCK_ID = "ON", ID = 5)
  logic [3:0]  l_awid;
  logic [31:0] l_awaddr;
  logic [7:0]  l_awlen;
  logic        l_awvalid, l_awready;
  logic [63:0] l_wdata;
  logic [7:0]  l_wstrb;
  logic        l_wlast, l_wvalid, l_wready;
  logic [3:0]  l_bid;
  logic [1:0]  l_bresp;
  logic        l_bvalid, l_bready;
  logic        l_mem_we;
  logic [31:0] l_mem_addr;
  logic [63:0] l_mem_wdata;
  logic [7:0]  l_mem_wstrb;
  logic        l_burst_done;
  logic [15:0] l_len_err_cnt;

  axi_wr_burst_sink #(.ADDR_STEP(STEP)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .axi_awid(awid), .axi_awaddr(awaddr), .axi_awlen(awlen),
    .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast),
    .axi_wvalid(wvalid), .axi_wready(wready),
    .axi_bid(bid), .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .burst_done(burst_done), .len_err_cnt(len_err_cnt)
  );

  axi_wr_burst_sink #(.ADDR_STEP(STEP), .ID(5), .LOCK_ID("ON")) dut_lock (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .axi_awid(l_awid), .axi_awaddr(l_awaddr), .axi_awlen(l_awlen),
    .axi_awvalid(l_awvalid), .axi_awready(l_awready),
    .axi_wdata(l_wdata), .axi_wstrb(l_wstrb), .axi_wlast(l_wlast),
    .axi_wvalid(l_wvalid), .axi_wready(l_wready),
    .axi_bid(l_bid), .axi_bresp(l_bresp), .axi_bvalid(l_bvalid), .axi_bready(l_bready),
    .mem_we(l_mem_we), .mem_addr(l_mem_addr), .mem_wdata(l_mem_wdata), .mem_wstrb(l_mem_wstrb),
    .burst_done(l_burst_done), .len_err_cnt(l_len_err_cnt)
  );

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } wr_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } b_t;

  wr_t wq[$];
  b_t  bq[$];

  int checks = 0;
  int passes = 0;
  int exp_err_cnt = 0;
  bit pend_b = 1'b0;
  int seen_ready = 0;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Scoreboard monitor: compares every memory write and every B handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_b = 1'b0;
      exp_err_cnt = 0;
    end else begin
      if (pend_b) begin
        check("burst_done_pulse", burst_done, 1'b1);
        check("len_err_cnt", len_err_cnt, exp_err_cnt);
        pend_b = 1'b0;
      end else if (burst_done) begin
        check("burst_done_spurious", burst_done, 1'b0);
      end
      if (mem_we) begin
        if (wq.size() == 0) begin
          check("mem_we_unexpected", mem_we, 1'b0);
        end else begin
          wr_t e;
          e = wq.pop_front();
          check("mem_write", {mem_addr, mem_wdata, mem_wstrb}, {e.addr, e.data, e.strb});
        end
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          check("b_unexpected", bvalid, 1'b0);
        end else begin
          b_t e;
          e = bq.pop_front();
          check("b_response", {bid, bresp}, {e.id, e.resp});
          if (e.resp == 2'b10 && exp_err_cnt < 65535) exp_err_cnt++;
          pend_b = 1'b1;
        end
      end
    end
  end

  // Wait for ready/valid on the main instance: 0 = awready, 1 = wready, 2 = bvalid.
  // Returns at #1 after the posedge that completes the handshake.
  task automatic wait_hs(input int which);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if ((which == 0 && awready) || (which == 1 && wready) || (which == 2 && bvalid)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      $display("FAIL handshake_timeout: channel %0d got no handshake, required one within 2000 cycles", which);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model: exp = awlen+1 beats. The first min(nbeats, exp) beats are written at
  // addr + i*STEP (mod 2^32). The response is OKAY only if nbeats == exp.
  task automatic do_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input int nbeats, input bit gaps);
    int  expn;
    b_t  be;
    wr_t we;
    expn    = int'(len) + 1;
    be.id   = id;
    be.resp = (nbeats == expn) ? 2'b00 : 2'b10;
    bq.push_back(be);
    awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
    wait_hs(0);
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (gaps) idle_cycles($urandom_range(0, 2));
      wdata  = {$urandom, $urandom};
      wstrb  = 8'($urandom);
      wlast  = (i == nbeats - 1);
      wvalid = 1'b1;
      if (i < expn) begin
        we.addr = addr + 32'(i * STEP);
        we.data = wdata;
        we.strb = wstrb;
        wq.push_back(we);
      end
      wait_hs(1);
      wvalid = 1'b0;
      wlast  = 1'b0;
    end
    if (gaps) idle_cycles($urandom_range(0, 3));
    bready = 1'b1;
    wait_hs(2);
    bready = 1'b0;
    $display("burst id=%0d addr=%08h awlen=%0d beats=%0d expect_resp=%0d", id, addr, len, nbeats, be.resp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    l_awid = '0; l_awaddr = '0; l_awlen = '0; l_awvalid = 1'b0;
    l_wdata = '0; l_wstrb = '0; l_wlast = 1'b0; l_wvalid = 1'b0; l_bready = 1'b0;

    #1;
    check("reset_ctrl", {awready, wready, bvalid, bid, bresp, mem_we, burst_done, len_err_cnt}, '0);
    check("reset_mem", {mem_addr, mem_wdata, mem_wstrb}, '0);
    idle_cycles(3);
    rst_n = 1'b1;
    #1;
    check("idle_awready", awready, 1'b1);
    check("idle_wready", wready, 1'b0);

    // Directed cases.
    do_burst(4'd2, 32'h0000_0100, 8'd3, 4, 1'b0);
    do_burst(4'd1, 32'h0000_0200, 8'd3, 2, 1'b0);
    do_burst(4'd7, 32'h0000_0300, 8'd1, 4, 1'b0);
    do_burst(4'd3, 32'hFFFF_FFFF, 8'd1, 2, 1'b0);
    do_burst(4'd9, 32'h0000_1000, 8'd0, 1, 1'b0);

    // Randomized bursts.
    for (int n = 0; n < 40; n++) begin
      logic [7:0]  len;
      logic [31:0] addr;
      int          beats;
      len  = 8'($urandom_range(0, 7));
      addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3))) : $urandom;
      if ($urandom_range(0, 9) < 7) beats = int'(len) + 1;
      else beats = $urandom_range(1, int'(len) + 4);
      do_burst(4'($urandom), addr, len, beats, 1'b1);
    end

    // Maximum-length burst.
    do_burst(4'd15, 32'h0001_0000, 8'hFF, 256, 1'b0);

    // Reset in the middle of a 4-beat burst, after beat 2.
    awid = 4'd4; awaddr = 32'h0000_0040; awlen = 8'd3; awvalid = 1'b1;
    wait_hs(0);
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_t we;
      wdata = {$urandom, $urandom}; wstrb = 8'hFF; wvalid = 1'b1;
      we.addr = 32'h0000_0040 + 32'(i); we.data = wdata; we.strb = wstrb;
      wq.push_back(we);
      wait_hs(1);
      wvalid = 1'b0;
    end
    idle_cycles(2);
    check("writes_before_reset", wq.size(), 0);
    rst_n = 1'b0;
    #1;
    check("midburst_reset_ctrl", {awready, wready, bvalid, bid, bresp, mem_we, burst_done, len_err_cnt}, '0);
    check("midburst_reset_mem", {mem_addr, mem_wdata, mem_wstrb}, '0);
    idle_cycles(3);
    rst_n = 1'b1;
    #1;
    check("after_reset_bvalid", bvalid, 1'b0);
    check("after_reset_awready", awready, 1'b1);
    do_burst(4'd6, 32'h0000_0500, 8'd0, 1, 1'b0);

    // ID lock: a request with a mismatching ID is held off, and a matching ID is accepted at once.
    l_awid = 4'd3; l_awaddr = 32'h0000_0700; l_awlen = 8'd0; l_awvalid = 1'b1;
    seen_ready = 0;
    repeat (20) begin
      @(negedge clk);
      if (l_awready) seen_ready++;
    end
    check("lock_reject_cycles", seen_ready, 0);
    l_awid = 4'd5;
    #1;
    check("lock_accept_same_cycle", l_awready, 1'b1);
    @(posedge clk);
    #1;
    l_awvalid = 1'b0;
    check("lock_awready_busy", l_awready, 1'b0);
    l_wdata = 64'h0123_4567_89AB_CDEF; l_wstrb = 8'h0F; l_wlast = 1'b1; l_wvalid = 1'b1;
    @(negedge clk);
    check("lock_wready", l_wready, 1'b1);
    @(posedge clk);
    #1;
    l_wvalid = 1'b0; l_wlast = 1'b0;
    check("lock_mem_write", {l_mem_we, l_mem_addr, l_mem_wdata, l_mem_wstrb},
          {1'b1, 32'h0000_0700, 64'h0123_4567_89AB_CDEF, 8'h0F});
    check("lock_b", {l_bvalid, l_bid, l_bresp}, {1'b1, 4'd5, 2'b00});
    l_bready = 1'b1;
    @(posedge clk);
    #1;
    l_bready = 1'b0;
    check("lock_done", {l_burst_done, l_bvalid, l_awready, l_len_err_cnt}, {1'b1, 1'b0, 1'b1, 16'd0});
    $display("burst id=5 addr=00000700 awlen=0 beats=1 on locked instance");

    idle_cycles(5);
    check("wq_drained", wq.size(), 0);
    check("bq_drained", bq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/axi_wr_burst_sink.md
Name: axi_wr_burst_sink

Overview:
- Synthesizable AXI4 write-channel slave that terminates the write bursts the bus monitor observes.
- Accepts one AW request at a time, sinks the W beats, and drives each beat onto a simple memory write port with incrementing address.
- Checks the actual burst length against AWLEN and returns a B response: OKAY on a match, SLVERR on a mismatch.
- Sits directly downstream of the mirror on the same AXI bus; the mirror's capture must match this block's memory writes beat for beat.

Parameters:
- ASIZE, 32, address width.
- DSIZE, 64, data width; multiple of 8.
- IDSIZE, 4, AXI ID width.
- LSIZE, 8, AWLEN width.
- ADDR_STEP, 1, memory address increment per accepted beat.
- ID, 0, ID accepted when LOCK_ID="ON".
- LOCK_ID, "OFF", "ON" accepts only AWID==ID; "OFF" accepts any ID.

Ports:
- axi_aclk  in  1  clock.
- axi_aresetn  in  1  asynchronous active-low reset.
- axi_awid  in  IDSIZE  write ID.
- axi_awaddr  in  ASIZE  burst start address.
- axi_awlen  in  LSIZE  beats minus 1.
- axi_awvalid  in  1  AW valid.
- axi_awready  out  1  AW ready.
- axi_wdata  in  DSIZE  write data.
- axi_wstrb  in  DSIZE/8  byte strobes.
- axi_wlast  in  1  last beat.
- axi_wvalid  in  1  W valid.
- axi_wready  out  1  W ready.
- axi_bid  out  IDSIZE  response ID.
- axi_bresp  out  2  response: 2'b00 OKAY, 2'b10 SLVERR.
- axi_bvalid  out  1  B valid.
- axi_bready  in  1  B ready.
- mem_we  out  1  memory write strobe, one cycle per beat.
- mem_addr  out  ASIZE  memory address.
- mem_wdata  out  DSIZE  memory data.
- mem_wstrb  out  DSIZE/8  memory byte enables.
- burst_done  out  1  one-cycle pulse when B handshake completes.
- len_err_cnt  out  16  count of SLVERR bursts; saturates at 16'hFFFF.

Behaviour:
- Reset (asynchronous, axi_aresetn=0):
  - State goes to IDLE.
  - awready, wready, bvalid, mem_we and burst_done are 0.
  - bresp, bid, mem_addr, mem_wdata, mem_wstrb and len_err_cnt are 0.
  - Reset asserted mid-burst abandons the burst: no B is issued and nothing further is written.
- State IDLE:
  - awready = (LOCK_ID=="OFF" || axi_awid==ID); awready is combinational from awid and does not wait on awvalid.
  - On an AW handshake: latch cur_addr=awaddr, exp_len=awlen+1 (LSIZE+1 bits wide, so awlen=all-ones is correct), bid=awid; clear beat_cnt and the err flag; go to DATA.
  - With LOCK_ID="ON" and an ID mismatch, awready stays 0 and the request stalls on the bus.
- State DATA:
  - wready=1 and awready=0.
  - On each W handshake: beat_cnt++.
  - If beat_cnt < exp_len before the increment, the next cycle drives mem_we=1 with mem_addr=cur_addr, mem_wdata=wdata and mem_wstrb=wstrb (registered, latency 1); then cur_addr += ADDR_STEP, wrapping modulo 2^ASIZE.
  - Beats beyond exp_len (overrun) are accepted but not written, and set err.
  - wlast on the beat where the post-increment count is below exp_len (early last) sets err.
  - wlast ends the burst: go to RESP. Without wlast the block stays in DATA indefinitely.
- State RESP:
  - wready=0 and bvalid=1.
  - bresp=2'b10 if err, else 2'b00. bid and bresp stay stable while bvalid is high.
  - On bready&&bvalid: bvalid drops next cycle, burst_done pulses for 1 cycle, len_err_cnt increments if err (saturating), and the state returns to IDLE.
  - awready is 1 again in the cycle after the B handshake, so there is exactly one outstanding burst.
- Registered outputs and back-to-back timing:
  - mem_we from the final beat is asserted during the first RESP cycle.
  - AW accepted to first W accepted: minimum 1 cycle.
  - wlast accepted to bvalid: 1 cycle.
- Ignored inputs: W beats presented in IDLE are not accepted (wready=0); AW presented in DATA or RESP is not accepted.

Test Plan:
- AWADDR=0x100, AWLEN=3, ID=2, 4 beats D0..D3 with wlast on beat 4:
  - mem writes at 0x100,0x101,0x102,0x103 carrying D0..D3;
  - then BRESP=00, BID=2, burst_done pulses once, len_err_cnt=0.
- AWLEN=3 with wlast on beat 2:
  - 2 mem writes, then BRESP=10;
  - len_err_cnt=1.
- AWLEN=1 with 4 beats, wlast on beat 4:
  - only 2 mem writes, all 4 beats accepted, then BRESP=10.
- AWADDR=0xFFFFFFFF, ADDR_STEP=1, AWLEN=1:
  - mem_addr 0xFFFFFFFF then 0x00000000;
  - BRESP=00.
- LOCK_ID="ON", ID=5:
  - AW with ID=3 is held and awready stays 0 for 20 cycles;
  - an AW with ID=5 is accepted in the same cycle it is presented.
- Reset mid-burst:
  - assert axi_aresetn=0 after beat 2 of 4: all outputs go to 0 immediately and no B is issued;
  - after release, a new AWLEN=0 burst completes with BRESP=00.
